// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side arbiter.
// Holds the arbiter state enum and the requester id width helper.
package fifo_pkg;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_GRANT = 1'b1
    } rd_arb_state_t;

    // Width of a requester index; never below 1 bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NUM_REQ_DEF = 4;
    localparam int ID_W_DEF    = id_w(NUM_REQ_DEF);

endpackage

// File: rtl/fifo_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req at or after rr_ptr.
// Ports: req, rr_ptr in; one-hot pick and its index pick_id out.
module rr_pick
    import fifo_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [ID_W-1:0]    pick_id
);

    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        pick    = '0;
        pick_id = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                found     = 1'b1;
                pick[idx] = 1'b1;
                pick_id   = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Shares one async-FIFO read port among NUM_REQ consumers, round-robin,
// in bursts of up to BURST pops; a grant is also released on owner drop
// or after STALL_MAX empty cycles. Ports: rclk/rrst (async, active low),
// req, rempty, rdata in; rinc, gnt, busy, out_valid/out_data/out_id out.
module fifo_read_arbiter
    import fifo_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST      = 4,
    parameter int STALL_MAX  = 8
) (
    input  logic                       rclk,
    input  logic                       rrst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       rempty,
    input  logic [DATA_WIDTH-1:0]      rdata,
    output logic                       rinc,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       busy,
    output logic                       out_valid,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [$clog2(NUM_REQ)-1:0] out_id
);

    localparam int ID_W  = id_w(NUM_REQ);
    localparam int CNT_W = $clog2(BURST + 1);
    localparam int ST_W  = $clog2(STALL_MAX + 1);

    rd_arb_state_t         state_q, state_d;
    logic [ID_W-1:0]       owner_q, owner_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ST_W-1:0]       stall_q, stall_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [ID_W-1:0]       out_id_q, out_id_d;

    logic [NUM_REQ-1:0]    pick;
    logic [ID_W-1:0]       pick_id;
    logic                  granted;
    logic                  owner_req;
    logic                  pop;
    logic                  drop;
    logic                  last_pop;
    logic                  timeout;
    logic [ID_W-1:0]       rr_next;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .pick    (pick),
        .pick_id (pick_id)
    );

    assign granted   = (state_q == RD_GRANT);
    assign owner_req = req[owner_q];
    // Only a granted, still-requesting owner with data may pop.
    assign pop       = granted & owner_req & ~rempty;
    assign drop      = granted & ~owner_req;
    assign last_pop  = pop & (cnt_q == CNT_W'(BURST - 1));
    assign timeout   = granted & owner_req & rempty
                     & (stall_q == ST_W'(STALL_MAX - 1));
    assign rr_next   = (owner_q == ID_W'(NUM_REQ - 1))
                     ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        stall_d     = stall_q;
        out_valid_d = pop;
        out_data_d  = pop ? rdata : out_data_q;
        out_id_d    = pop ? owner_q : out_id_q;
        unique case (state_q)
            RD_IDLE: begin
                if (|req && !rempty) begin
                    state_d = RD_GRANT;
                    owner_d = pick_id;
                    gnt_d   = pick;
                    cnt_d   = '0;
                    stall_d = '0;
                end
            end
            RD_GRANT: begin
                if (pop) begin
                    if (cnt_q != CNT_W'(BURST))
                        cnt_d = cnt_q + 1'b1;
                    stall_d = '0;
                end else if (rempty) begin
                    if (stall_q != ST_W'(STALL_MAX))
                        stall_d = stall_q + 1'b1;
                end
                if (drop || last_pop || timeout) begin
                    state_d  = RD_IDLE;
                    gnt_d    = '0;
                    rr_ptr_d = rr_next;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            state_q     <= RD_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            cnt_q       <= '0;
            stall_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            stall_q     <= stall_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

    assign rinc      = pop;
    assign gnt       = gnt_q;
    assign busy      = granted;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Directed bench for fifo_read_arbiter with a behavioural FIFO model.
// Drives inputs #1 after posedge and samples on the negedge.
module tb_fifo_read_arbiter;

    logic       rclk = 1'b0;
    logic       rrst = 1'b1;
    logic [3:0] req  = '0;
    logic       rempty;
    logic [7:0] rdata;
    logic       rinc;
    logic [3:0] gnt;
    logic       busy;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_id;

    fifo_read_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .BURST      (4),
        .STALL_MAX  (8)
    ) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .req       (req),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .gnt       (gnt),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    always #5 rclk = ~rclk;

    logic [7:0] mem [0:63];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       force_empty = 1'b0;

    // FIFO state only changes just after a posedge, so rempty acts
    // like a registered flag.
    assign rempty = force_empty || (wr_ptr == rd_ptr);
    assign rdata  = mem[rd_ptr % 64];

    int total = 0;
    int bad   = 0;

    logic [7:0] obs_data [$];
    int         obs_id   [$];
    int         gorder   [$];
    int         pops_id  [4];
    int         gcyc     [4];
    int         pops_tot;
    int         underflow;
    logic [3:0] prev_gnt;
    logic [3:0] last_gnt;
    logic       last_busy;
    logic       last_rinc;
    logic [31:0] hist;
    int         cidx;
    logic       pend;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int oh2i(input logic [3:0] v);
        for (int i = 0; i < 4; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    task automatic clr_mon();
        obs_data.delete();
        obs_id.delete();
        gorder.delete();
        for (int i = 0; i < 4; i++) begin
            pops_id[i] = 0;
            gcyc[i]    = 0;
        end
        pops_tot  = 0;
        underflow = 0;
        prev_gnt  = gnt;
        hist      = '0;
        cidx      = 0;
    endtask

    task automatic push(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr % 64] = base + 8'(i);
            wr_ptr++;
        end
    endtask

    // One clock cycle: observe at negedge, apply the pop after posedge.
    task automatic cyc();
        @(negedge rclk);
        pend      = rinc;
        last_gnt  = gnt;
        last_busy = busy;
        last_rinc = rinc;
        if (rinc && rempty) underflow++;
        if (rinc) begin
            pops_tot++;
            if (gnt != 0) pops_id[oh2i(gnt)]++;
        end
        if (gnt != 0) gcyc[oh2i(gnt)]++;
        if (gnt != 0 && prev_gnt == 0) gorder.push_back(oh2i(gnt));
        prev_gnt = gnt;
        if (out_valid) begin
            obs_data.push_back(out_data);
            obs_id.push_back(int'(out_id));
        end
        if (cidx < 32) hist[cidx] = rinc;
        cidx++;
        @(posedge rclk);
        #1;
        if (pend) rd_ptr++;
    endtask

    task automatic do_reset();
        req         = '0;
        force_empty = 1'b0;
        rrst        = 1'b0;
        wr_ptr      = 0;
        rd_ptr      = 0;
        repeat (2) @(posedge rclk);
        #1;
        rrst = 1'b1;
        clr_mon();
    endtask

    int mis;

    initial begin
        // Reset state
        #1 rrst = 1'b0;
        repeat (2) @(posedge rclk);
        #1;
        check("rst_rinc", int'(rinc), 0);
        check("rst_gnt", int'(gnt), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_oval", int'(out_valid), 0);
        check("rst_odata", int'(out_data), 0);
        check("rst_oid", int'(out_id), 0);

        // 1: single requester, 10 words, bursts of 4
        do_reset();
        push(10, 8'h10);
        req = 4'b0001;
        repeat (14) cyc();
        check("t1_rinc_pat", int'(hist[13:0]), 'h1BDE);
        check("t1_nout", obs_data.size(), 10);
        mis = 0;
        foreach (obs_data[i])
            if (obs_data[i] != 8'h10 + 8'(i) || obs_id[i] != 0) mis++;
        check("t1_order", mis, 0);

        // 2: round robin with all requesting
        do_reset();
        push(40, 8'h40);
        req = 4'b1111;
        repeat (26) cyc();
        check("t2_ngrant", gorder.size(), 5);
        for (int i = 0; i < 5; i++)
            check("t2_gorder",
                  (i < gorder.size()) ? gorder[i] : -1, i % 4);
        check("t2_nout", obs_id.size(), 20);
        mis = 0;
        foreach (obs_id[i])
            if (obs_id[i] != (i / 4) % 4 ||
                obs_data[i] != 8'h40 + 8'(i)) mis++;
        check("t2_ids", mis, 0);

        // 3: owner 2 drops after two pops
        do_reset();
        push(20, 8'h80);
        req = 4'b1100;
        repeat (3) cyc();
        req = 4'b1000;
        cyc();
        check("t3_drop_rinc", int'(last_rinc), 0);
        check("t3_drop_gnt", int'(last_gnt), 4);
        cyc();
        check("t3_idle_busy", int'(last_busy), 0);
        cyc();
        check("t3_next_gnt", int'(last_gnt), 8);
        check("t3_pops2", pops_id[2], 2);

        // 4: one word then empty stall timeout
        do_reset();
        push(1, 8'hA5);
        req = 4'b0010;
        repeat (12) cyc();
        check("t4_pops", pops_tot, 1);
        check("t4_gcyc", gcyc[1], 9);
        check("t4_under", underflow, 0);
        check("t4_gnt_end", int'(last_gnt), 0);
        check("t4_data", (obs_data.size() > 0) ? int'(obs_data[0]) : -1,
              'hA5);

        // 5: empty at arbitration
        do_reset();
        force_empty = 1'b1;
        push(4, 8'h20);
        req = 4'b0110;
        repeat (3) cyc();
        check("t5_hold_gnt", gcyc[1] + gcyc[2], 0);
        check("t5_hold_busy", int'(last_busy), 0);
        force_empty = 1'b0;
        cyc();
        check("t5_idle_gnt", int'(last_gnt), 0);
        cyc();
        check("t5_gnt", int'(last_gnt), 2);

        // 6: reset in the middle of a burst
        do_reset();
        push(30, 8'h60);
        req = 4'b0110;
        repeat (8) cyc();
        check("t6_pre_gnt", int'(last_gnt), 4);
        check("t6_pre_pops", pops_id[2], 2);
        rrst = 1'b0;
        #1;
        check("t6_rinc", int'(rinc), 0);
        check("t6_gnt", int'(gnt), 0);
        check("t6_oval", int'(out_valid), 0);
        check("t6_busy", int'(busy), 0);
        @(posedge rclk);
        #1;
        rrst = 1'b1;
        clr_mon();
        req = 4'b1111;
        repeat (2) cyc();
        check("t6_first_gnt", int'(last_gnt), 1);

        req = '0;
        repeat (2) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_read_arbiter.md
# fifo_read_arbiter

Read-domain scheduler that shares one async-FIFO read port among `NUM_REQ` consumers. It runs on the FIFO read clock and grants the port to one requester at a time, round-robin, for bursts of up to `BURST` words. It drives the read pointer's `rinc` from the grant and the registered `rempty` flag. Popped words are returned to the granted consumer through a registered valid/data/id stream.

## Interface
Parameters:
- `NUM_REQ`, 4: number of consumers; at least 2.
- `DATA_WIDTH`, 8: FIFO word width.
- `BURST`, 4: maximum pops per grant; at least 1.
- `STALL_MAX`, 8: number of consecutive empty cycles during a grant before the grant is released.

Ports:
- `rclk`  in  1: read-domain clock. All logic is on the posedge.
- `rrst`  in  1: asynchronous, active-low reset.
- `req`  in  `NUM_REQ`: level requests, one per consumer.
- `rempty`  in  1: registered FIFO empty flag.
- `rdata`  in  `DATA_WIDTH`: FIFO word at the current `raddr`. It is combinational from memory and valid in the same cycle as `rinc`.
- `rinc`  out  1: pop strobe to the read pointer.
- `gnt`  out  `NUM_REQ`: one-hot grant, registered.
- `busy`  out  1: high when the FSM is in GRANT.
- `out_valid`  out  1: registered; high for one cycle per popped word.
- `out_data`  out  `DATA_WIDTH`: popped word.
- `out_id`  out  `$clog2(NUM_REQ)`: index of the requester that owns `out_data`.

## Operation
- FSM has two states: IDLE and GRANT.
- **IDLE:**
  - `rinc` is 0.
  - If `|req` and `!rempty`, the round-robin picker selects the first asserted `req` at or after `rr_ptr`, wrapping modulo `NUM_REQ`.
  - On the next edge: load `owner`, set `gnt`, clear `cnt` and `stall`, go to GRANT.
  - Requests seen while `rempty` are ignored; the FSM stays in IDLE.
- **GRANT:**
  - `rinc = req[owner] & ~rempty`. This is the only path that asserts `rinc`.
  - Each pop increments `cnt`, which is `$clog2(BURST+1)` bits wide and saturates at `BURST`.
  - Each pop also clears `stall`.
  - While `rempty` is high, `stall` increments.
- **GRANT exit conditions.** On the exiting edge: go to IDLE, clear `gnt`, set `rr_ptr = owner+1` (mod `NUM_REQ`). Exit when any of these holds:
  - a pop occurs with `cnt == BURST-1`, so the burst is complete;
  - `req[owner]` is low, in which case no pop happens that cycle;
  - `stall == STALL_MAX-1` and `rempty` is high.
- **Data path.** On every pop, `out_data <= rdata`, `out_id <= owner` and `out_valid <= 1`. Otherwise `out_valid <= 0`.
- **Other requests.** Requests from non-owners are held off; they are never lost and are re-arbitrated in IDLE.
- **Simultaneous events.**
  - Owner drop and `rempty` in the same cycle: the exit reason is owner drop.
  - Last pop and owner drop cannot coincide, because a pop requires `req[owner]`.
- **Reset.** When `rrst` goes low, at any time including mid-burst, outputs clear asynchronously:
  - state goes to IDLE;
  - `rinc`, `gnt`, `busy`, `out_valid`, `out_data` and `out_id` go to 0;
  - `rr_ptr`, `cnt`, `stall` and `owner` go to 0.

## Timing
- Arbitration to first pop: the request is sampled in IDLE at cycle N, `gnt` is high from N+1, and the first `rinc` is at N+1 if `!rempty`.
- Pop to output: a `rinc` in cycle N gives `out_valid` in cycle N+1, carrying the word that was at `raddr` in cycle N.
- Back-to-back pops: one per cycle within a grant.
- Gap between grants: at least one IDLE cycle, so a full burst occupies `BURST`+1 cycles.
- `rinc` is combinational from the registered state, `gnt`, `req` and `rempty`. Consumers must drive `req` from registers.
- Because `rempty` is registered, a stale-empty cycle only delays pops. It can never cause an underflow pop.

## Structure
- Shared package `fifo_pkg`:
  - state enum `rd_arb_state_t` with values `RD_IDLE` and `RD_GRANT`;
  - localparam helper for id width, `$clog2(NUM_REQ)`.
- Sub-module `rr_pick`:
  - combinational round-robin picker;
  - inputs: `req` vector and `rr_ptr`;
  - outputs: one-hot `pick` and index `pick_id`.
- The FSM, counters and output register stay in `fifo_read_arbiter`.

## Test plan
Parameters for all scenarios: `NUM_REQ`=4, `BURST`=4, `STALL_MAX`=8.
1. **Single requester, full burst.** FIFO holds 10 words; `req`=4'b0001 held.
   - `rinc` high for 4 cycles, then 1 IDLE cycle, then 4 more pops.
   - `out_id`=0; `out_data` matches FIFO order, with no drop or duplicate.
2. **Round-robin fairness.** `req`=4'b1111, FIFO never empty.
   - Grant order is 0,1,2,3,0.
   - Each grant produces exactly 4 `out_valid` pulses with the matching `out_id`.
3. **Owner drops request.** Requester 2 deasserts `req[2]` after 2 pops.
   - The pop count for that grant is exactly 2; the FSM returns to IDLE the same cycle.
   - Next grant goes to 3 if `req[3]` is set.
4. **Empty stall and timeout.** FIFO holds 1 word; requester 1 is granted.
   - 1 pop, then `rinc` stays 0 while `rempty`.
   - Grant is released after 8 empty cycles.
   - No pop ever occurs while `rempty`=1.
5. **Empty at arbitration.** `rempty`=1 with `req`=4'b0110: `gnt` stays 0.
   - After `rempty` falls, `gnt`=4'b0010 on the next cycle.
6. **Reset mid-burst.** Assert `rrst`=0 after the 2nd pop of a grant.
   - `rinc`, `gnt` and `out_valid` go to 0 immediately.
   - After release, the first grant goes to requester 0 (`rr_ptr`=0).
